// File: rtl/ce_pix_pkg.sv
// ce_pix_pkg: shared types and constants for the pixel clock-enable generator.
//   mode_e   : video mode (native / scandoubled)
//   state_e  : mode-switch state machine states
//   INC_DIV2 : NCO increment giving clk/2 for a 16-bit accumulator
//   INC_DIV4 : NCO increment giving clk/4 for a 16-bit accumulator
package ce_pix_pkg;

  typedef enum logic {
    MODE_NATIVE = 1'b0,
    MODE_DOUBLE = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam logic [15:0] INC_DIV2 = 16'h8000;
  localparam logic [15:0] INC_DIV4 = 16'h4000;

endpackage

// File: rtl/ce_nco.sv
// ce_nco: phase-accumulator NCO. Every cycle {carry, acc} <= acc + inc;
// the carry is the one-cycle pixel enable.
// Ports:
//   clk_sys  in          clock
//   reset    in          asynchronous active-high reset
//   clr      in          synchronous clear of accumulator and carry
//   inc      in  ACC_W   increment, sampled live
//   carry    out         registered carry of the last add
//   acc      out ACC_W   accumulator value
module ce_nco #(
  parameter int ACC_W = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             clr,
  input  logic [ACC_W-1:0] inc,
  output logic             carry,
  output logic [ACC_W-1:0] acc
);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      carry <= 1'b0;
    end else begin
      // One bit wider than the accumulator: top bit is the wrap carry.
      {carry, acc} <= {1'b0, acc} + {1'b0, inc};
    end
  end

endmodule

// File: rtl/ce_pix_gen.sv
// ce_pix_gen: pixel clock-enable generator with two programmable NCO rates
// (native / scandoubled) and glitch-free mode switching.
// Optional feature macro: CE_PIX_LINE_ALIGN_EN
//   defined   : a requested mode change is applied on the next hsync rising edge
//   undefined : hsync is ignored; the change is applied one cycle after detection
// Ports:
//   clk_sys            in          clock
//   reset              in          asynchronous active-high reset
//   forced_scandoubler in          requested mode (0 native, 1 doubled)
//   inc_native         in  ACC_W   NCO increment in native mode
//   inc_double         in  ACC_W   NCO increment in doubled mode
//   hsync              in          horizontal sync, rising edge is the switch point
//   ce_pix             out         one-cycle pixel enable
//   ce_half            out         every second ce_pix
//   mode_active        out         mode currently in effect
//   switch_pending     out         request differs from mode_active, not yet applied
module ce_pix_gen
  import ce_pix_pkg::*;
#(
  parameter int ACC_W       = 16,
  parameter bit HALF_EN_RST = 1'b1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             forced_scandoubler,
  input  logic [ACC_W-1:0] inc_native,
  input  logic [ACC_W-1:0] inc_double,
  input  logic             hsync,
  output logic             ce_pix,
  output logic             ce_half,
  output logic             mode_active,
  output logic             switch_pending
);

  mode_e            mode_reg;
  state_e           state_reg;
  logic             phase_reg;
  mode_e            req_mode;
  logic             switch_ok;
  logic             do_switch;
  logic [ACC_W-1:0] inc_sel;
  logic [ACC_W-1:0] acc;

  assign req_mode = mode_e'(forced_scandoubler);

`ifdef CE_PIX_LINE_ALIGN_EN
  logic hsync_d;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) hsync_d <= 1'b0;
    else       hsync_d <= hsync;
  end

  assign switch_ok = hsync & ~hsync_d;
`else
  // Without line alignment the switch happens one cycle after detection.
  logic unused_hsync;
  assign unused_hsync = hsync;
  assign switch_ok    = 1'b1;
`endif

  // A request that reverts on the switch cycle wins: no switch, no clear.
  assign do_switch = (state_reg == ST_PENDING) && (req_mode != mode_reg) && switch_ok;

  assign inc_sel = (mode_reg == MODE_DOUBLE) ? inc_double : inc_native;

  ce_nco #(
    .ACC_W (ACC_W)
  ) u_nco (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (do_switch),
    .inc     (inc_sel),
    .carry   (ce_pix),
    .acc     (acc)
  );

  // acc is only observed for debug; nothing downstream consumes it.
  logic unused_acc;
  assign unused_acc = ^acc;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      mode_reg  <= MODE_NATIVE;
      phase_reg <= 1'b0;
    end else begin
      if (do_switch && HALF_EN_RST) phase_reg <= 1'b0;
      else if (ce_pix)              phase_reg <= ~phase_reg;

      case (state_reg)
        ST_IDLE: begin
          if (req_mode != mode_reg) state_reg <= ST_PENDING;
        end
        ST_PENDING: begin
          if (req_mode == mode_reg) begin
            state_reg <= ST_IDLE;
          end else if (switch_ok) begin
            mode_reg  <= req_mode;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Phase is sampled before its toggle, so the first pulse after a clear
  // never raises ce_half.
  assign ce_half        = ce_pix & phase_reg;
  assign mode_active    = (mode_reg == MODE_DOUBLE);
  assign switch_pending = (state_reg == ST_PENDING);

endmodule

// File: tb/tb_ce_pix_gen.sv
// tb_ce_pix_gen: self-checking bench for ce_pix_gen (ACC_W=16, HALF_EN_RST=1).
// Expected outputs are pushed to a scoreboard queue at each clock edge and
// popped/compared 1 time unit later; directed checks cover edge positions,
// average rate, mode switching, request revert and reset while pending.
module tb_ce_pix_gen;

  typedef struct packed {
    logic ce;
    logic half;
    logic mode;
    logic pend;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        fs      = 1'b0;
  logic        hsync   = 1'b0;
  logic [15:0] inc_native = 16'h4000;
  logic [15:0] inc_double = 16'h8000;
  logic        ce_pix, ce_half, mode_active, switch_pending;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic [15:0] m_acc;
  logic        m_ce, m_phase, m_mode, m_pend, m_hd;
  exp_t        sb_q[$];

  always #5 clk_sys = ~clk_sys;

  ce_pix_gen #(
    .ACC_W       (16),
    .HALF_EN_RST (1'b1)
  ) dut (
    .clk_sys            (clk_sys),
    .reset              (reset),
    .forced_scandoubler (fs),
    .inc_native         (inc_native),
    .inc_double         (inc_double),
    .hsync              (hsync),
    .ce_pix             (ce_pix),
    .ce_half            (ce_half),
    .mode_active        (mode_active),
    .switch_pending     (switch_pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_acc = '0; m_ce = 0; m_phase = 0; m_mode = 0; m_pend = 0; m_hd = 0;
  endtask

  // One clock: advance model from the inputs held across the edge, push the
  // expectation, then pop and compare against the DUT after the edge.
  task automatic tick();
    exp_t        e, got;
    logic        sw_ok, sw, rise;
    logic [15:0] inc;
    logic [16:0] sum;
    logic        o_pend, o_mode;
    @(posedge clk_sys);
    if (reset) begin
      model_reset();
    end else begin
      rise = hsync && !m_hd;
`ifdef CE_PIX_LINE_ALIGN_EN
      sw_ok = rise;
`else
      sw_ok = 1'b1;
`endif
      o_pend = m_pend;
      o_mode = m_mode;
      inc    = o_mode ? inc_double : inc_native;
      sw     = o_pend && (fs != o_mode) && sw_ok;
      m_phase = sw ? 1'b0 : (m_phase ^ m_ce);
      if (sw) begin
        m_acc  = '0;
        m_ce   = 1'b0;
        m_mode = fs;
      end else begin
        sum   = {1'b0, m_acc} + {1'b0, inc};
        m_ce  = sum[16];
        m_acc = sum[15:0];
      end
      if (!o_pend)          m_pend = (fs != o_mode);
      else if (fs == o_mode) m_pend = 1'b0;
      else if (sw)           m_pend = 1'b0;
      m_hd = hsync;
    end
    e.ce = m_ce; e.half = m_ce & m_phase; e.mode = m_mode; e.pend = m_pend;
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    check("ce_pix", ce_pix, got.ce);
    check("ce_half", ce_half, got.half);
    check("mode_active", mode_active, got.mode);
    check("switch_pending", switch_pending, got.pend);
  endtask

  initial begin
    logic [15:0] mask_ce, mask_half;
    logic [7:0]  mask8;
    int          cnt, pend_cnt, wait_n;
    logic        prev, dbl;

    model_reset();
    repeat (3) tick();
    check("reset_ce_pix", ce_pix, 0);
    check("reset_ce_half", ce_half, 0);
    check("reset_mode", mode_active, 0);
    check("reset_pending", switch_pending, 0);
    reset = 1'b0;

    // edges 1..16 after release with inc 0x4000
    mask_ce = '0; mask_half = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      mask_ce[i]   = ce_pix;
      mask_half[i] = ce_half;
    end
    check("ce_pix_edges_4_8_12_16", mask_ce, 16'h8888);
    check("ce_half_edges_8_16", mask_half, 16'h8080);
    $display("step: div4 edges ce=%h half=%h", mask_ce, mask_half);

    // average rate with inc 0x5555: 3072 * 0x5555 / 2^16 = 1023.98
    inc_native = 16'h5555;
    cnt = 0; prev = 0; dbl = 0;
    for (int i = 0; i < 3072; i++) begin
      tick();
      if (ce_pix) cnt++;
      if (ce_pix && prev) dbl = 1;
      prev = ce_pix;
    end
    n_total++;
    assert (cnt >= 1023 && cnt <= 1025) n_pass++;
    else $error("FAIL rate_5555 observed=%0d required=1023..1025", cnt);
    check("no_back_to_back", dbl, 0);
    $display("step: inc 0x5555 pulses=%0d in 3072 cycles", cnt);

    // zero increment never fires
    inc_native = 16'h0000;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ce_pix) cnt++;
    end
    check("inc_zero_silent", cnt, 0);
    inc_native = 16'h4000;
    $display("step: inc 0 pulses=%0d", cnt);

    // request reverts before being applied: no switch
    fs = 1'b1;
`ifdef CE_PIX_LINE_ALIGN_EN
    repeat (5) tick();
`else
    tick();
`endif
    check("revert_pending_seen", switch_pending, 1);
    fs = 1'b0;
    tick();
    check("revert_pending_cleared", switch_pending, 0);
    hsync = 1'b1; tick();
    hsync = 1'b0; repeat (4) tick();
    check("revert_mode_kept", mode_active, 0);
    $display("step: revert mode=%0d", mode_active);

    // switch to doubled mode at 0x8000
    inc_double = 16'h8000;
    fs = 1'b1;
    pend_cnt = 0;
`ifdef CE_PIX_LINE_ALIGN_EN
    wait_n = 100;
`else
    wait_n = 1;
`endif
    for (int i = 0; i < wait_n; i++) begin
      tick();
      if (switch_pending) pend_cnt++;
    end
    hsync = 1'b1;
    tick();
    if (switch_pending) pend_cnt++;
    check("switch_mode_applied", mode_active, 1);
    check("switch_ce_cleared", ce_pix, 0);
    check("switch_pending_cycles", pend_cnt, wait_n);
    hsync = 1'b0;
    mask8 = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      mask8[i] = ce_pix;
    end
    check("double_cadence", mask8, 8'hAA);
    $display("step: switch pending=%0d cadence=%h", pend_cnt, mask8);

    // reset while pending
    fs = 1'b0;
    tick();
    check("pending_before_reset", switch_pending, 1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("async_ce_pix", ce_pix, 0);
    check("async_ce_half", ce_half, 0);
    check("async_mode", mode_active, 0);
    check("async_pending", switch_pending, 0);
    fs = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("redetect_after_reset", switch_pending, 1);
    hsync = 1'b1; tick();
    hsync = 1'b0; repeat (4) tick();
    check("final_mode", mode_active, 1);
    $display("step: reset while pending, final mode=%0d", mode_active);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
